cci_mpf_csr_event_mgr: RTL and testbench
========================================

Name: cci_mpf_csr_event_mgr

Overview:
- Manager end of the MPF CSR interface.
- Decodes host MMIO writes into shim control outputs (VTP mode, page-table base, VC map control).
- Accumulates the single-cycle event wires from the VTP and VC-map shims into saturating counters.
- Answers host MMIO reads of control, event, history and WRO statistics registers through a small response FIFO that drains into the CCI TX MMIO channel.

Parameters:
- CSR_BASE_ADDR, 16'h0100: byte address of register 0; must be 128-byte aligned.
- EVENT_CTR_BITS, 48: width of each event counter; zero-extended to 64 on read.
- RSP_FIFO_DEPTH, 4: read-response FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active low
- mmio_wr_valid  in  1  MMIO write strobe
- mmio_wr_addr  in  16  byte address
- mmio_wr_data  in  64  write data
- mmio_rd_valid  in  1  MMIO read request strobe
- mmio_rd_addr  in  16  byte address
- mmio_rd_tid  in  9  transaction id
- rsp_valid  out  1  read response strobe
- rsp_tid  out  9  echoed tid
- rsp_data  out  64  read data
- rsp_almost_full  in  1  TX MMIO channel cannot accept a response this cycle
- rsp_overflow  out  1  sticky: response dropped because the FIFO was full
- events  in  7  [0]4kb_hit [1]4kb_miss [2]2mb_hit [3]2mb_miss [4]pt_walk_busy [5]failed_translation [6]mapping_changed
- vtp_in_mode  out  8  VTP page-table mode
- vtp_in_page_table_base  out  42  page-table line address
- vtp_in_page_table_base_valid  out  1  page-table base programmed
- vc_map_ctrl  out  64  VC map control word
- vc_map_ctrl_valid  out  1  one-cycle pulse on a new vc_map_ctrl
- vc_map_history  in  64  VC map history
- wro_stats  in  256  WRO counters {read_conflicts, write_conflicts, reads, writes}, writes in [63:0]

Behaviour:
- Register window is [CSR_BASE_ADDR, CSR_BASE_ADDR+0x80) with 8-byte registers. Address bits [2:0] are ignored.
- Register map (offset: name, access):
  - 0x00: VTP_MODE, RW, bits [7:0]
  - 0x08: VTP_PT_BASE, RW, bits [41:0]
  - 0x10: VC_MAP_CTRL, RW
  - 0x18: VC_MAP_HISTORY, RO
  - 0x20–0x50: EVENT[0..6], read returns the count; write of any value clears that counter
  - 0x58–0x70: WRO[0..3], RO
  - 0x78: VERSION, RO, constant 64'h1
- Accesses outside the window:
  - Writes are ignored.
  - Reads produce no response; another responder owns them.
- Writes to RO registers are ignored.
- Write timing: a write accepted in cycle N updates the target output at N+1.
  - vc_map_ctrl_valid is high for exactly cycle N+1.
  - vtp_in_page_table_base_valid sets at N+1 and stays high until reset.
- Event path:
  - events is registered once, so an event in cycle N is reflected in its counter at N+2.
  - Counters saturate at all ones; they never wrap.
  - Multiple event bits in the same cycle each increment their own counter.
- Clear vs event on the same counter and cycle: clear wins, then the registered event still counts, so the counter reads 1. If no event is pending, the counter reads 0.
- Read pipeline:
  - Request in cycle N is registered; the register mux is evaluated at N+1 and pushed to the FIFO at N+1.
  - The FIFO head is issued when non-empty and !rsp_almost_full.
  - Minimum latency: rsp_valid at N+2.
  - Responses leave in request order.
  - Data is the register value sampled at N+1.
- FIFO full at push time:
  - The response is dropped and rsp_overflow sets (sticky until reset).
  - Same-cycle pop and push when full succeeds with no drop.
- Simultaneous mmio_wr_valid and mmio_rd_valid to the same register: the read returns the pre-write value.
- Reset (reset_n low at a rising edge):
  - All outputs, counters and control registers go to 0.
  - FIFO empties; rsp_valid=0; rsp_overflow=0.
  - In-flight reads are discarded with no response after reset deasserts.

Decomposition:
- Package cci_mpf_csr_mgr_pkg holds:
  - register offset localparams
  - typedef t_mpf_csr_event_idx, an enum of the 7 event indices
  - typedef t_mpf_csr_event_ctr, logic [EVENT_CTR_BITS-1:0]
  - MPF_CSR_VERSION constant
- One sub-module, cci_mpf_csr_event_ctr: a single saturating counter with clear and increment inputs implementing the clear-vs-event rule. Instantiate it 7 times.
- The response FIFO is inline.

Test Plan:
- Write VTP_PT_BASE=42'h123456 at cycle 10 -> vtp_in_page_table_base=42'h123456 and valid=1 at cycle 11; read of 0x08 returns 64'h123456.
- Pulse events[0] for 5 cycles starting at cycle 20 -> read of 0x20 issued after cycle 26 returns 5; EVENT[1..6] read 0.
- Hold events[2] with the counter preloaded to all ones by forcing -> read returns 64'h0000_FFFF_FFFF_FFFF; no wrap.
- Write 0x20 in the same cycle registered events[0]=1 arrives -> subsequent read returns 1.
- Hold rsp_almost_full=1 and issue 5 reads with tids 1..5 -> rsp_overflow=1; releasing it yields exactly tids 1..4 in order, and no response for tid 5.
- Assert reset_n=0 for 1 cycle with 2 reads in flight -> no rsp_valid afterwards; all outputs 0; vc_map_ctrl_valid never pulses.

Source files
------------

// File: rtl/cci_mpf_csr_mgr_pkg.sv
// MPF CSR manager shared definitions.
// Register offsets, event indices and counter types.
package cci_mpf_csr_mgr_pkg;

    localparam int MPF_CSR_EVENT_CTR_BITS = 48;
    localparam int MPF_CSR_NUM_EVENTS     = 7;
    localparam int MPF_CSR_NUM_WRO        = 4;

    // Byte offsets inside the 128-byte register window
    localparam logic [6:0] MPF_CSR_VTP_MODE       = 7'h00;
    localparam logic [6:0] MPF_CSR_VTP_PT_BASE    = 7'h08;
    localparam logic [6:0] MPF_CSR_VC_MAP_CTRL    = 7'h10;
    localparam logic [6:0] MPF_CSR_VC_MAP_HISTORY = 7'h18;
    localparam logic [6:0] MPF_CSR_EVENT_BASE     = 7'h20;
    localparam logic [6:0] MPF_CSR_WRO_BASE       = 7'h58;
    localparam logic [6:0] MPF_CSR_VERSION_OFF    = 7'h78;

    localparam logic [63:0] MPF_CSR_VERSION = 64'h1;

    typedef enum logic [2:0] {
        EVT_4KB_HIT         = 3'd0,
        EVT_4KB_MISS        = 3'd1,
        EVT_2MB_HIT         = 3'd2,
        EVT_2MB_MISS        = 3'd3,
        EVT_PT_WALK_BUSY    = 3'd4,
        EVT_FAILED_XLATE    = 3'd5,
        EVT_MAPPING_CHANGED = 3'd6
    } t_mpf_csr_event_idx;

    typedef logic [MPF_CSR_EVENT_CTR_BITS-1:0] t_mpf_csr_event_ctr;

endpackage

// File: rtl/cci_mpf_csr_event_ctr.sv
// Saturating event counter with synchronous clear.
// A clear coinciding with an increment leaves the count at 1.
module cci_mpf_csr_event_ctr
    import cci_mpf_csr_mgr_pkg::*;
#(
    parameter int W = MPF_CSR_EVENT_CTR_BITS
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear has priority but still absorbs the same-cycle event
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= W'(i_inc);
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cci_mpf_csr_event_mgr.sv
// MPF CSR manager: MMIO write decode, event counters,
// and an ordered read-response FIFO toward the TX MMIO channel.
module cci_mpf_csr_event_mgr
    import cci_mpf_csr_mgr_pkg::*;
#(
    parameter logic [15:0] CSR_BASE_ADDR  = 16'h0100,
    parameter int          EVENT_CTR_BITS = MPF_CSR_EVENT_CTR_BITS,
    parameter int          RSP_FIFO_DEPTH = 4
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mmio_wr_valid,
    input  logic [15:0]  mmio_wr_addr,
    input  logic [63:0]  mmio_wr_data,
    input  logic         mmio_rd_valid,
    input  logic [15:0]  mmio_rd_addr,
    input  logic [8:0]   mmio_rd_tid,
    output logic         rsp_valid,
    output logic [8:0]   rsp_tid,
    output logic [63:0]  rsp_data,
    input  logic         rsp_almost_full,
    output logic         rsp_overflow,
    input  logic [6:0]   events,
    output logic [7:0]   vtp_in_mode,
    output logic [41:0]  vtp_in_page_table_base,
    output logic         vtp_in_page_table_base_valid,
    output logic [63:0]  vc_map_ctrl,
    output logic         vc_map_ctrl_valid,
    input  logic [63:0]  vc_map_history,
    input  logic [255:0] wro_stats
);

    localparam logic [3:0] IDX_MODE    = MPF_CSR_VTP_MODE[6:3];
    localparam logic [3:0] IDX_PT      = MPF_CSR_VTP_PT_BASE[6:3];
    localparam logic [3:0] IDX_VC      = MPF_CSR_VC_MAP_CTRL[6:3];
    localparam logic [3:0] IDX_HIST    = MPF_CSR_VC_MAP_HISTORY[6:3];
    localparam logic [3:0] IDX_EVT0    = MPF_CSR_EVENT_BASE[6:3];
    localparam logic [3:0] IDX_WRO0    = MPF_CSR_WRO_BASE[6:3];
    localparam logic [3:0] IDX_VERSION = MPF_CSR_VERSION_OFF[6:3];

    localparam int         AW      = $clog2(RSP_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  r_vtp_mode;
    logic [41:0] r_pt_base;
    logic        r_pt_valid;
    logic [63:0] r_vc_ctrl;
    logic        r_vc_valid;
    logic [6:0]  r_events;

    logic        w_wr_hit;
    logic        w_rd_hit;
    logic [3:0]  w_wr_idx;
    logic [3:0]  w_rd_idx;
    logic        w_rd_coll;
    logic [6:0]  w_clr;
    logic [EVENT_CTR_BITS-1:0] w_ctr [MPF_CSR_NUM_EVENTS];
    logic [63:0] w_regs [16];
    logic        w_unused_addr;

    assign w_wr_idx  = mmio_wr_addr[6:3];
    assign w_rd_idx  = mmio_rd_addr[6:3];
    assign w_wr_hit  = mmio_wr_valid &&
                       (mmio_wr_addr[15:7] == CSR_BASE_ADDR[15:7]);
    assign w_rd_hit  = mmio_rd_valid &&
                       (mmio_rd_addr[15:7] == CSR_BASE_ADDR[15:7]);
    assign w_rd_coll = w_rd_hit && w_wr_hit && (w_rd_idx == w_wr_idx);
    assign w_unused_addr = ^{mmio_wr_addr[2:0], mmio_rd_addr[2:0]};

    // Control register writes; vc_map_ctrl_valid is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vtp_mode <= '0;
            r_pt_base  <= '0;
            r_pt_valid <= 1'b0;
            r_vc_ctrl  <= '0;
            r_vc_valid <= 1'b0;
        end else begin
            r_vc_valid <= 1'b0;
            if (w_wr_hit) begin
                case (w_wr_idx)
                    IDX_MODE: r_vtp_mode <= mmio_wr_data[7:0];
                    IDX_PT: begin
                        r_pt_base  <= mmio_wr_data[41:0];
                        r_pt_valid <= 1'b1;
                    end
                    IDX_VC: begin
                        r_vc_ctrl  <= mmio_wr_data;
                        r_vc_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register the event wires once before counting
    always_ff @(posedge clk) begin
        if (!reset_n) r_events <= '0;
        else          r_events <= events;
    end

    // Any write to an event register clears that counter
    always_comb begin
        for (int e = 0; e < MPF_CSR_NUM_EVENTS; e++) begin
            w_clr[e] = w_wr_hit && (w_wr_idx == IDX_EVT0 + 4'(e));
        end
    end

    for (genvar e = 0; e < MPF_CSR_NUM_EVENTS; e++) begin : g_ctr
        cci_mpf_csr_event_ctr #(.W(EVENT_CTR_BITS)) u_ctr (
            .clk     (clk),
            .reset_n (reset_n),
            .i_clr   (w_clr[e]),
            .i_inc   (r_events[e]),
            .o_count (w_ctr[e])
        );
    end

    // Readable register view indexed by address bits [6:3]
    always_comb begin
        for (int i = 0; i < 16; i++) w_regs[i] = '0;
        w_regs[IDX_MODE] = 64'(r_vtp_mode);
        w_regs[IDX_PT]   = 64'(r_pt_base);
        w_regs[IDX_VC]   = r_vc_ctrl;
        w_regs[IDX_HIST] = vc_map_history;
        for (int e = 0; e < MPF_CSR_NUM_EVENTS; e++) begin
            w_regs[IDX_EVT0 + 4'(e)] = 64'(w_ctr[e]);
        end
        for (int k = 0; k < MPF_CSR_NUM_WRO; k++) begin
            w_regs[IDX_WRO0 + 4'(k)] = wro_stats[64*k +: 64];
        end
        w_regs[IDX_VERSION] = MPF_CSR_VERSION;
    end

    logic        r_rd_valid;
    logic [8:0]  r_rd_tid;
    logic [3:0]  r_rd_idx;
    logic        r_rd_coll;
    logic [63:0] r_rd_snap;
    logic [63:0] w_rd_data;

    // Read request stage; snapshot protects against a same-cycle write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_tid   <= '0;
            r_rd_idx   <= '0;
            r_rd_coll  <= 1'b0;
            r_rd_snap  <= '0;
        end else begin
            r_rd_valid <= w_rd_hit;
            r_rd_tid   <= mmio_rd_tid;
            r_rd_idx   <= w_rd_idx;
            r_rd_coll  <= w_rd_coll;
            r_rd_snap  <= w_regs[w_rd_idx];
        end
    end

    assign w_rd_data = r_rd_coll ? r_rd_snap : w_regs[r_rd_idx];

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [8:0]  r_fifo_tid  [RSP_FIFO_DEPTH];
    logic [63:0] r_fifo_data [RSP_FIFO_DEPTH];
    logic        r_overflow;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && !rsp_almost_full;
    assign w_push  = r_rd_valid && (!w_full || w_pop);

    // Response storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_tid[r_wr_ptr[AW-1:0]]  <= r_rd_tid;
            r_fifo_data[r_wr_ptr[AW-1:0]] <= w_rd_data;
        end
    end

    // FIFO pointers and sticky drop flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (r_rd_valid && !w_push) r_overflow <= 1'b1;
        end
    end

    assign rsp_valid    = w_pop;
    assign rsp_tid      = w_pop ? r_fifo_tid[r_rd_ptr[AW-1:0]] : '0;
    assign rsp_data     = w_pop ? r_fifo_data[r_rd_ptr[AW-1:0]] : '0;
    assign rsp_overflow = r_overflow;

    assign vtp_in_mode                  = r_vtp_mode;
    assign vtp_in_page_table_base       = r_pt_base;
    assign vtp_in_page_table_base_valid = r_pt_valid;
    assign vc_map_ctrl                  = r_vc_ctrl;
    assign vc_map_ctrl_valid            = r_vc_valid;

endmodule

// File: tb/tb_cci_mpf_csr_event_mgr.sv
// Bench for cci_mpf_csr_event_mgr: vector table plus
// hand sequences, responses checked through a scoreboard queue.
module tb_cci_mpf_csr_event_mgr;
    import cci_mpf_csr_mgr_pkg::*;

    localparam logic [15:0]  BASE = 16'h0100;
    localparam logic [63:0]  HIST = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [255:0] WRO  = {64'h4444_0000_0000_0004,
                                     64'h3333_0000_0000_0003,
                                     64'h2222_0000_0000_0002,
                                     64'h1111_0000_0000_0001};
    localparam logic [63:0]  SAT  = 64'h0000_FFFF_FFFF_FFFF;

    logic         clk;
    logic         reset_n;
    logic         mmio_wr_valid;
    logic [15:0]  mmio_wr_addr;
    logic [63:0]  mmio_wr_data;
    logic         mmio_rd_valid;
    logic [15:0]  mmio_rd_addr;
    logic [8:0]   mmio_rd_tid;
    logic         rsp_valid;
    logic [8:0]   rsp_tid;
    logic [63:0]  rsp_data;
    logic         rsp_almost_full;
    logic         rsp_overflow;
    logic [6:0]   events;
    logic [7:0]   vtp_in_mode;
    logic [41:0]  vtp_in_page_table_base;
    logic         vtp_in_page_table_base_valid;
    logic [63:0]  vc_map_ctrl;
    logic         vc_map_ctrl_valid;
    logic [63:0]  vc_map_history;
    logic [255:0] wro_stats;

    cci_mpf_csr_event_mgr dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .mmio_wr_valid                (mmio_wr_valid),
        .mmio_wr_addr                 (mmio_wr_addr),
        .mmio_wr_data                 (mmio_wr_data),
        .mmio_rd_valid                (mmio_rd_valid),
        .mmio_rd_addr                 (mmio_rd_addr),
        .mmio_rd_tid                  (mmio_rd_tid),
        .rsp_valid                    (rsp_valid),
        .rsp_tid                      (rsp_tid),
        .rsp_data                     (rsp_data),
        .rsp_almost_full              (rsp_almost_full),
        .rsp_overflow                 (rsp_overflow),
        .events                       (events),
        .vtp_in_mode                  (vtp_in_mode),
        .vtp_in_page_table_base       (vtp_in_page_table_base),
        .vtp_in_page_table_base_valid (vtp_in_page_table_base_valid),
        .vc_map_ctrl                  (vc_map_ctrl),
        .vc_map_ctrl_valid            (vc_map_ctrl_valid),
        .vc_map_history               (vc_map_history),
        .wro_stats                    (wro_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [15:0] waddr;
        logic [63:0] wdata;
        logic [15:0] raddr;
        logic [63:0] exp;
    } vec_t;

    rsp_t sb[$];
    vec_t vecs[12];
    int   checks;
    int   errors;
    int   n_rsp;
    int   n_exp;
    int   vc_pulses;
    int   pulses_before;
    logic [8:0] tid_n;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d);
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = a;
        mmio_wr_data  = d;
        @(posedge clk); #1;
        mmio_wr_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [15:0] a, input logic [63:0] e_data,
                              input bit expect_rsp);
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = a;
        mmio_rd_tid   = tid_n;
        if (expect_rsp) begin
            sb.push_back(rsp_t'{tid_n, e_data});
            n_exp++;
        end
        tid_n++;
        @(posedge clk); #1;
        mmio_rd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i = 0;
        while (sb.size() != 0 && i < 60) begin
            @(posedge clk);
            i++;
        end
        @(posedge clk); #1;
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Response monitor: compare each response against the scoreboard head
    always @(negedge clk) begin
        rsp_t e;
        if (vc_map_ctrl_valid) vc_pulses++;
        if (rsp_valid) begin
            n_rsp++;
            if (rsp_almost_full) begin
                checks++;
                errors++;
                $display("FAIL rsp_while_almost_full tid %h", rsp_tid);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp tid %h data %h", rsp_tid, rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_tid", 64'(rsp_tid), 64'(e.tid));
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; n_rsp = 0; n_exp = 0;
        vc_pulses = 0; pulses_before = 0; tid_n = 9'd0;
        reset_n = 1'b0;
        mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_data = '0;
        mmio_rd_valid = 1'b0; mmio_rd_addr = '0; mmio_rd_tid = '0;
        rsp_almost_full = 1'b0;
        events = '0;
        vc_map_history = HIST;
        wro_stats = WRO;

        vecs[0]  = '{1'b1, BASE + 16'h00, 64'h1234_5678_9ABC_DEF0,
                     BASE + 16'h00, 64'hF0};
        vecs[1]  = '{1'b1, BASE + 16'h08, 64'hFFFF_FFFF_FFFF_FFFF,
                     BASE + 16'h08, 64'h0000_03FF_FFFF_FFFF};
        vecs[2]  = '{1'b1, BASE + 16'h10, 64'hDEAD_BEEF_0123_4567,
                     BASE + 16'h10, 64'hDEAD_BEEF_0123_4567};
        vecs[3]  = '{1'b1, BASE + 16'h18, 64'h1, BASE + 16'h18, HIST};
        vecs[4]  = '{1'b1, BASE + 16'h78, 64'h0, BASE + 16'h78, 64'h1};
        vecs[5]  = '{1'b0, 16'h0, 64'h0, BASE + 16'h58, WRO[63:0]};
        vecs[6]  = '{1'b0, 16'h0, 64'h0, BASE + 16'h60, WRO[127:64]};
        vecs[7]  = '{1'b0, 16'h0, 64'h0, BASE + 16'h68, WRO[191:128]};
        vecs[8]  = '{1'b0, 16'h0, 64'h0, BASE + 16'h70, WRO[255:192]};
        vecs[9]  = '{1'b1, 16'h0180, 64'h77, BASE + 16'h00, 64'hF0};
        vecs[10] = '{1'b1, BASE + 16'h07, 64'h3C, BASE + 16'h00, 64'h3C};
        vecs[11] = '{1'b1, 16'h0080, 64'h55, BASE + 16'h04, 64'h3C};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("reset_mode", 64'(vtp_in_mode), 64'd0);
        chk("reset_pt_base", 64'(vtp_in_page_table_base), 64'd0);
        chk("reset_pt_valid", 64'(vtp_in_page_table_base_valid), 64'd0);
        chk("reset_vc_ctrl", vc_map_ctrl, 64'd0);
        chk("reset_vc_valid", 64'(vc_map_ctrl_valid), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_overflow", 64'(rsp_overflow), 64'd0);

        do_write(BASE + 16'h08, 64'h123456);
        chk("pt_base_out", 64'(vtp_in_page_table_base), 64'h123456);
        chk("pt_valid_out", 64'(vtp_in_page_table_base_valid), 64'd1);
        issue_read(BASE + 16'h08, 64'h123456, 1'b1);
        wait_drain("drain_pt");

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].waddr, vecs[i].wdata);
            issue_read(vecs[i].raddr, vecs[i].exp, 1'b1);
        end
        issue_read(16'h0180, 64'h0, 1'b0);
        wait_drain("drain_table");

        do_write(BASE + 16'h10, 64'hCAFE);
        chk("vc_ctrl_out", vc_map_ctrl, 64'hCAFE);
        chk("vc_valid_pulse", 64'(vc_map_ctrl_valid), 64'd1);
        @(posedge clk); #1;
        chk("vc_valid_drop", 64'(vc_map_ctrl_valid), 64'd0);

        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = BASE + 16'h10;
        mmio_wr_data  = 64'hBEEF;
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = BASE + 16'h10;
        mmio_rd_tid   = tid_n;
        sb.push_back(rsp_t'{tid_n, 64'hCAFE});
        n_exp++;
        tid_n++;
        @(posedge clk); #1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        issue_read(BASE + 16'h10, 64'hBEEF, 1'b1);
        wait_drain("drain_coll");

        events = 7'b0000001;
        repeat (5) @(posedge clk);
        #1 events = '0;
        repeat (2) @(posedge clk);
        #1;
        issue_read(BASE + 16'h20, 64'd5, 1'b1);
        for (int e = 1; e < 7; e++) begin
            issue_read(BASE + 16'h20 + 16'(8 * e), 64'd0, 1'b1);
        end
        wait_drain("drain_evt5");

        events = 7'b1111110;
        repeat (2) @(posedge clk);
        #1 events = '0;
        repeat (3) @(posedge clk);
        #1;
        issue_read(BASE + 16'h20, 64'd5, 1'b1);
        for (int e = 1; e < 7; e++) begin
            issue_read(BASE + 16'h20 + 16'(8 * e), 64'd2, 1'b1);
        end
        wait_drain("drain_multi");

        events = 7'b0000001;
        @(posedge clk); #1;
        events = '0;
        do_write(BASE + 16'h20, 64'h0);
        do_write(BASE + 16'h28, 64'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        issue_read(BASE + 16'h20, 64'd1, 1'b1);
        issue_read(BASE + 16'h28, 64'd0, 1'b1);
        wait_drain("drain_clr");

        @(negedge clk);
        force dut.g_ctr[2].u_ctr.r_count = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.g_ctr[2].u_ctr.r_count;
        events = 7'b0000100;
        repeat (4) @(posedge clk);
        #1 events = '0;
        repeat (2) @(posedge clk);
        #1;
        issue_read(BASE + 16'h30, SAT, 1'b1);
        issue_read(BASE + 16'h38, 64'd2, 1'b1);
        wait_drain("drain_sat");

        rsp_almost_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue_read(BASE + 16'h58 + 16'(8 * i),
                       (i < 4) ? WRO[64*i +: 64] : 64'h1, 1'b1);
        end
        rsp_almost_full = 1'b0;
        wait_drain("drain_full_pop");
        chk("no_overflow_on_pop", 64'(rsp_overflow), 64'd0);

        rsp_almost_full = 1'b1;
        tid_n = 9'd1;
        for (int i = 0; i < 5; i++) begin
            issue_read(BASE + 16'h58 + 16'(8 * i),
                       (i < 4) ? WRO[64*i +: 64] : 64'h1, (i < 4));
        end
        repeat (2) @(posedge clk);
        #1;
        chk("overflow_set", 64'(rsp_overflow), 64'd1);
        rsp_almost_full = 1'b0;
        wait_drain("drain_ovf");
        repeat (3) @(posedge clk);
        #1;
        chk("overflow_sticky", 64'(rsp_overflow), 64'd1);

        rsp_almost_full = 1'b1;
        issue_read(BASE + 16'h78, 64'h1, 1'b0);
        issue_read(BASE + 16'h78, 64'h1, 1'b0);
        pulses_before = vc_pulses;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        rsp_almost_full = 1'b0;
        chk("rst2_mode", 64'(vtp_in_mode), 64'd0);
        chk("rst2_pt_base", 64'(vtp_in_page_table_base), 64'd0);
        chk("rst2_pt_valid", 64'(vtp_in_page_table_base_valid), 64'd0);
        chk("rst2_vc_ctrl", vc_map_ctrl, 64'd0);
        chk("rst2_overflow", 64'(rsp_overflow), 64'd0);
        chk("rst2_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("rst2_vc_pulses", 64'(vc_pulses - pulses_before), 64'd0);
        issue_read(BASE + 16'h20, 64'd0, 1'b1);
        issue_read(BASE + 16'h10, 64'd0, 1'b1);
        wait_drain("drain_rst2");

        chk("rsp_count", 64'(n_rsp), 64'(n_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
